shift_chain_ctrl: RTL
=====================

SHIFT_CHAIN_CTRL -- requirements
Module: shift_chain_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 576, length in bits of the controlled shift chain.
REQ-002 Parameter WORD_W, default 8, parallel word width; CHAIN_LEN SHALL be an integer multiple of WORD_W.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a full chain pass.
REQ-006 in_valid  input  1  write word available.
REQ-007 in_data  input  WORD_W  word to shift into the chain, LSB first.
REQ-008 in_ready  output  1  controller accepts in_data this cycle.
REQ-009 chain_shift_in  output  1  serial bit driven into the chain.
REQ-010 chain_shift_en  output  1  chain advances one bit on this clock edge.
REQ-011 chain_out  input  1  chain's last bit, i.e. the bit leaving on the next enabled edge.
REQ-012 out_valid  output  1  readback word available.
REQ-013 out_data  output  WORD_W  readback word; first bit out of the chain in bit 0.
REQ-014 out_ready  input  1  consumer takes out_data this cycle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at pass completion.

Function
REQ-017 States: IDLE, FETCH, SHIFT, DRAIN, DONE; encoding is free.
REQ-018 IDLE: in_ready=0, chain_shift_en=0; start=1 -> FETCH, bit total cleared to 0; start in any other state is ignored.
REQ-019 FETCH: in_ready = !out_valid; in_valid & in_ready latches in_data into the word buffer and moves to SHIFT next cycle.
REQ-020 SHIFT: chain_shift_en=1 for exactly WORD_W consecutive cycles; cycle k drives chain_shift_in = buffer[k] (k = 0..WORD_W-1).
REQ-021 SHIFT: each enabled cycle k samples chain_out into capture bit k; after cycle WORD_W-1 the capture word loads into out_data and out_valid sets.
REQ-022 After the last SHIFT cycle: bit total += WORD_W; total < CHAIN_LEN -> FETCH, total == CHAIN_LEN -> DRAIN.
REQ-023 out_valid clears on the cycle after out_valid & out_ready; out_data is held stable while out_valid=1 and out_ready=0.
REQ-024 DRAIN: waits for out_valid=0, then -> DONE.
REQ-025 DONE: done=1 for one cycle, busy=1, then -> IDLE.
REQ-026 Backpressure: FETCH does not accept a new word while out_valid=1, so readback words are never overwritten or dropped.
REQ-027 in_valid low in FETCH stalls indefinitely with chain_shift_en=0; the chain is never shifted without a full accepted word.
REQ-028 A pass shifts exactly CHAIN_LEN bits, issues CHAIN_LEN/WORD_W in handshakes and the same number of out handshakes, then one done pulse.
REQ-029 Bit total counter width is clog2(CHAIN_LEN+1); it never wraps within a pass.

Reset
REQ-030 clr=1 at any time, including mid-SHIFT, forces IDLE with total=0, in_ready=0, chain_shift_en=0, chain_shift_in=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-031 After clr deasserts, the block stays in IDLE until a new start; a partial pass is discarded and not resumed.
REQ-032 The chain is reset by the same clr, so the first pass after reset reads back all zeros.

Verification (CHAIN_LEN=16, WORD_W=8 unless noted)
REQ-033 Reset, start, write words 0xA5 and 0x3C, out_ready=1 -> 16 shift_en cycles, readback 0x00 then 0x00, done pulse, busy falls.
REQ-034 Second pass writing 0xFF and 0x01 -> readback 0xA5 then 0x3C, in that order.
REQ-035 Hold out_ready=0 after the first readback word -> in_ready stays 0, shift_en stays 0, out_data stays stable; release it -> the pass completes normally.
REQ-036 Deassert in_valid for 5 cycles in FETCH -> no shift_en during the gap; the total shift count stays 16.
REQ-037 Assert clr after 3 shift cycles of word 2 -> all outputs are 0 next cycle; a new start performs a full clean pass.
REQ-038 With default parameters (576/8), run one pass -> exactly 72 in handshakes, 72 out handshakes, 576 shift_en cycles and one done pulse.

Source files
------------

// File: rtl/shift_chain_ctrl_if.sv
// Handshake and chain-control bundle for shift_chain_ctrl.
// master is the environment side, slave is the controller side.
interface shift_chain_ctrl_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              chain_shift_in;
    logic              chain_shift_en;
    logic              chain_out;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, in_valid, in_data, out_ready, chain_out,
        input  in_ready, chain_shift_in, chain_shift_en,
        input  out_valid, out_data, busy, done
    );

    modport slave (
        input  start, in_valid, in_data, out_ready, chain_out,
        output in_ready, chain_shift_in, chain_shift_en,
        output out_valid, out_data, busy, done
    );
endinterface

// File: rtl/shift_chain_ctrl.sv
// Word-parallel controller for a serial shift chain: writes words in
// LSB first while capturing the bits that fall out as readback words.
module shift_chain_ctrl #(
    parameter int CHAIN_LEN = 576,
    parameter int WORD_W    = 8
) (
    input logic          clk,
    input logic          clr,
    shift_chain_ctrl_if.slave bus
);
    localparam int TW = $clog2(CHAIN_LEN + 1);
    localparam int KW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [TW-1:0] LEN   = TW'(CHAIN_LEN);
    localparam logic [TW-1:0] STEP  = TW'(WORD_W);
    localparam logic [KW-1:0] KLAST = KW'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [TW-1:0]     total_q;
    logic [TW-1:0]     total_d;
    logic [KW-1:0]     bit_q;
    logic [WORD_W-1:0] buf_q;
    logic [WORD_W-1:0] cap_q;
    logic [WORD_W-1:0] cap_d;
    logic [WORD_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              in_ready;
    logic              shift_en;

    assign total_d  = total_q + STEP;
    assign in_ready = (state_q == S_FETCH) && !out_valid_q;
    assign shift_en = (state_q == S_SHIFT);

    assign bus.in_ready       = in_ready;
    assign bus.chain_shift_en = shift_en;
    assign bus.chain_shift_in = shift_en & buf_q[bit_q];
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = (state_q == S_DONE);

    // Capture word with the current chain_out merged into bit k.
    always_comb begin
        cap_d        = cap_q;
        cap_d[bit_q] = bus.chain_out;
    end

    // Pass sequencing, word buffer, capture and readback register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            total_q     <= '0;
            bit_q       <= '0;
            buf_q       <= '0;
            cap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_FETCH;
                        total_q <= '0;
                    end
                end
                S_FETCH: begin
                    if (bus.in_valid && in_ready) begin
                        buf_q   <= bus.in_data;
                        bit_q   <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    cap_q <= cap_d;
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == KLAST) begin
                        out_data_q  <= cap_d;
                        out_valid_q <= 1'b1;
                        total_q     <= total_d;
                        state_q     <= (total_d == LEN) ? S_DRAIN
                                                        : S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (!out_valid_q) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
